// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Message front end for a SHA-256 core. Collects 32-bit big-endian message
// words into a 16-word block buffer. It applies the standard padding: an
// 0x80 marker, zero fill, and a 64-bit bit-length field. Each finished block
// is launched with a one-cycle start pulse and held until the core is done.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data is valid this cycle
//   in_ready   : padder accepts a word this cycle (high in FILL only)
//   in_data    : message word, byte 0 in [31:24]
//   in_last    : final word of the message
//   in_bytes   : valid bytes in the final word (1..4; 0 and 5..7 mean 4)
//   blk_data   : assembled block, word 0 in [511:480]
//   blk_start  : one-cycle launch pulse
//   blk_first  : block is the first of the message
//   blk_last   : block is the final block of the message
//   core_done  : core finished the current block (sampled in WAIT only)
//   msg_done   : one-cycle pulse when the final block completes
//
// state | meaning
// FILL  | accepting message words into the buffer
// PAD   | writing marker / zero / length words, one per cycle
// ISSUE | single-cycle blk_start
// WAIT  | block held stable until core_done
module sha256_msg_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [511:0] blk_data,
  output logic         blk_start,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         core_done,
  output logic         msg_done
);

  typedef enum logic [1:0] {FILL, PAD, ISSUE, WAIT} state_t;

  state_t       state, state_nx;
  logic [31:0]  blk_buf [16];
  logic [3:0]   idx;
  logic [63:0]  len;
  logic         seen_last, marker_written, len_ok, first;

  logic [2:0]   nb;
  logic [31:0]  last_word;
  logic [31:0]  pad_word;

  // Out-of-range byte counts fall back to a full word.
  assign nb = ((in_bytes == 3'd0) || (in_bytes > 3'd4)) ? 3'd4 : in_bytes;

  always_comb begin
    last_word = in_data;
    case (nb)
      3'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  always_comb begin
    pad_word = 32'h0;
    if (!marker_written)               pad_word = 32'h8000_0000;
    else if (idx == 4'd14 && len_ok)   pad_word = len[63:32];
    else if (idx == 4'd15 && len_ok)   pad_word = len[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    blk_start = 1'b0;
    msg_done  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx == 4'd15) state_nx = ISSUE;
          else if (in_last) state_nx = PAD;
        end
      end
      PAD: begin
        if (idx == 4'd15) state_nx = ISSUE;
      end
      ISSUE: begin
        blk_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          if (len_ok) begin
            msg_done = 1'b1;
            state_nx = FILL;
          end else if (seen_last || marker_written) begin
            state_nx = PAD;
          end else begin
            state_nx = FILL;
          end
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // The flags only change outside WAIT, so they are stable for the core.
  assign blk_first = first;
  assign blk_last  = len_ok;

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = blk_buf[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
      idx            <= '0;
      len            <= '0;
      seen_last      <= 1'b0;
      marker_written <= 1'b0;
      len_ok         <= 1'b0;
      first          <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            blk_buf[idx] <= in_last ? last_word : in_data;
            idx          <= idx + 4'd1;
            len          <= len + (in_last ? {58'd0, nb, 3'd0} : 64'd32);
            if (in_last) begin
              if (nb != 3'd4) begin
                marker_written <= 1'b1;
                if (idx <= 4'd13) len_ok <= 1'b1;
              end else begin
                seen_last <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          blk_buf[idx] <= pad_word;
          idx          <= idx + 4'd1;
          if (!marker_written) begin
            marker_written <= 1'b1;
            if (idx <= 4'd13) len_ok <= 1'b1;
          end
        end
        WAIT: begin
          if (core_done) begin
            idx <= '0;
            if (len_ok) begin
              len            <= '0;
              seen_last      <= 1'b0;
              marker_written <= 1'b0;
              len_ok         <= 1'b0;
              first          <= 1'b1;
            end else begin
              first <= 1'b0;
              // Marker already placed but no room for the length: one more block.
              if (marker_written) len_ok <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
